// File: rtl/river_crossing_ctrl.sv
// ---------------------------------------------------------------------------
// River crossing game controller (farmer / cabbage / goat / wolf).
//
// Purpose:
//   Accepts one move command per valid/ready handshake, tracks which bank
//   each character is on, flags unsafe positions, detects a win and counts
//   accepted moves. It loses the game when a move leaves an unsafe bank or
//   when the move limit runs out.
//
// Ports:
//   Clock       in   rising-edge system clock
//   Resetn      in   asynchronous active-low reset
//   restart     in   synchronous new-game request (wins over a move)
//   move_valid  in   move command present
//   move_sel    in   00 farmer alone, 01 cabbage, 10 goat, 11 wolf
//   move_ready  out  high while a game is in progress (PLAY)
//   F,C,G,W     out  bank of each character: 0 start bank, 1 far bank
//   alarm       out  current positions are unsafe
//   illegal     out  one-cycle pulse after a rejected move
//   win         out  game won
//   lose        out  game lost
//   move_count  out  accepted moves since reset/restart
// ---------------------------------------------------------------------------
module river_crossing_ctrl #(
  parameter int COUNT_W   = 4,
  parameter int MAX_MOVES = 15
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               restart,
  input  logic               move_valid,
  input  logic [1:0]         move_sel,
  output logic               move_ready,
  output logic               F,
  output logic               C,
  output logic               G,
  output logic               W,
  output logic               alarm,
  output logic               illegal,
  output logic               win,
  output logic               lose,
  output logic [COUNT_W-1:0] move_count
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WON  = 2'd1,
    LOST = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_f;
  logic               r_c;
  logic               r_g;
  logic               r_w;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_count;

  logic               w_sel_pos;
  logic               w_legal;
  logic               w_nf;
  logic               w_nc;
  logic               w_ng;
  logic               w_nw;
  logic               w_nalarm;
  logic [COUNT_W-1:0] w_ncount;

  // Bank of the character the farmer wants to take along; for a solo
  // crossing this is the farmer himself, so the move is always legal.
  always_comb begin
    w_sel_pos = r_f;
    case (move_sel)
      2'b01:   w_sel_pos = r_c;
      2'b10:   w_sel_pos = r_g;
      2'b11:   w_sel_pos = r_w;
      default: w_sel_pos = r_f;
    endcase
  end

  assign w_legal = (w_sel_pos == r_f);

  // Candidate positions if the offered move is accepted.
  assign w_nf     = ~r_f;
  assign w_nc     = r_c ^ (move_sel == 2'b01);
  assign w_ng     = r_g ^ (move_sel == 2'b10);
  assign w_nw     = r_w ^ (move_sel == 2'b11);
  assign w_ncount = r_count + COUNT_W'(1);

  // The goat is the troublemaker: unsafe whenever it is left without the
  // farmer together with either the wolf or the cabbage.
  assign w_nalarm = ((w_ng == w_nw) && (w_nf != w_ng)) ||
                    ((w_nc == w_ng) && (w_nf != w_ng));

  // Game state machine. Outcome is judged on the post-move positions so the
  // win/lose flags line up with the positions they describe; a win beats
  // both losing conditions.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= PLAY;
      r_f       <= 1'b0;
      r_c       <= 1'b0;
      r_g       <= 1'b0;
      r_w       <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else if (restart) begin
      r_state   <= PLAY;
      r_f       <= 1'b0;
      r_c       <= 1'b0;
      r_g       <= 1'b0;
      r_w       <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_illegal <= 1'b0;
      if ((r_state == PLAY) && move_valid) begin
        if (w_legal) begin
          r_f     <= w_nf;
          r_c     <= w_nc;
          r_g     <= w_ng;
          r_w     <= w_nw;
          r_count <= w_ncount;
          if (w_nf && w_nc && w_ng && w_nw) begin
            r_state <= WON;
          end else if (w_nalarm) begin
            r_state <= LOST;
          end else if (w_ncount == COUNT_W'(MAX_MOVES)) begin
            r_state <= LOST;
          end else begin
            r_state <= PLAY;
          end
        end else begin
          r_illegal <= 1'b1;
        end
      end
    end
  end

  assign F          = r_f;
  assign C          = r_c;
  assign G          = r_g;
  assign W          = r_w;
  assign illegal    = r_illegal;
  assign move_count = r_count;
  assign move_ready = (r_state == PLAY);
  assign win        = (r_state == WON);
  assign lose       = (r_state == LOST);

  // Alarm follows the registered positions with no extra latency.
  assign alarm = ((r_g == r_w) && (r_f != r_g)) ||
                 ((r_c == r_g) && (r_f != r_g));

endmodule
